vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_sync_delay.sv | 39 +++
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// VGA timing constants for the supported modes, plus the flag bundle shared by the generator.
// Pure definitions: no logic, no latency, no flow control.
package vga_pkg;

    // 1024x768 @ 70 Hz, 75 MHz pixel clock
    localparam int XGA70_PCLK_HZ   = 75_000_000;
    localparam int XGA70_H_ACTIVE  = 1024;
    localparam int XGA70_H_FP      = 24;
    localparam int XGA70_H_SYNC    = 136;
    localparam int XGA70_H_BP      = 144;
    localparam int XGA70_V_ACTIVE  = 768;
    localparam int XGA70_V_FP      = 3;
    localparam int XGA70_V_SYNC    = 6;
    localparam int XGA70_V_BP      = 29;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA60_PCLK_HZ  = 40_000_000;
    localparam int SVGA60_H_ACTIVE = 800;
    localparam int SVGA60_H_FP     = 40;
    localparam int SVGA60_H_SYNC   = 128;
    localparam int SVGA60_H_BP     = 88;
    localparam int SVGA60_V_ACTIVE = 600;
    localparam int SVGA60_V_FP     = 1;
    localparam int SVGA60_V_SYNC   = 4;
    localparam int SVGA60_V_BP     = 23;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblnk;
        logic vblnk;
    } flags_t;

    function automatic int total4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Sync/blank delay line: DEPTH ce-gated register stages on a 4-bit bundle, wire passthrough at DEPTH 0.
// Latency DEPTH ce-qualified cycles; stages hold while i_ce is low.
module vga_sync_delay #(
    parameter int         DEPTH   = 0,
    parameter logic [3:0] RST_VAL = 4'h0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic [3:0] i_dat,
    output logic [3:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_ce};
            assign o_dat    = i_dat;
        end else begin : g_shift
            logic [3:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_ce) begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync/blank decode, line/frame pulses, frame counter.
// All outputs registered; flags lag counts by SYNC_DELAY; everything holds while ce is low.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = XGA70_H_ACTIVE,
    parameter int H_FP       = XGA70_H_FP,
    parameter int H_SYNC     = XGA70_H_SYNC,
    parameter int H_BP       = XGA70_H_BP,
    parameter int V_ACTIVE   = XGA70_V_ACTIVE,
    parameter int V_FP       = XGA70_V_FP,
    parameter int V_SYNC     = XGA70_V_SYNC,
    parameter int V_BP       = XGA70_V_BP,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int CW         = 11,
    parameter int SYNC_DELAY = 0
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblnk,
    output logic          vblnk,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_BLANK = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_BLANK = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SBEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SEND  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SBEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SEND  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam flags_t FLAGS_RST = '{hsync: ~HS_ON, vsync: ~VS_ON, hblnk: 1'b0, vblnk: 1'b0};

    generate
        if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
            $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..7");
        end
    endgenerate

    logic          r_restart;
    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic [7:0]    r_frame_cnt;
    logic          r_line_start;
    logic          r_frame_start;
    flags_t        r_flags;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_line_evt;
    logic          w_frame_evt;
    flags_t        w_flags_nxt;
    flags_t        w_flags_dly;

    // After reset the first ce cycle lands on (0,0) instead of advancing, and is a line+frame start.
    always_comb begin
        w_h_wrap    = (r_hcount >= H_LAST);
        w_v_wrap    = (r_vcount >= V_LAST);
        w_h_nxt     = w_h_wrap ? '0 : r_hcount + CW'(1);
        w_v_nxt     = r_vcount;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_vcount + CW'(1);
        end
        w_line_evt  = w_h_wrap;
        w_frame_evt = w_h_wrap && w_v_wrap;
        if (r_restart) begin
            w_h_nxt     = '0;
            w_v_nxt     = '0;
            w_line_evt  = 1'b1;
            w_frame_evt = 1'b1;
        end
    end

    // Flags are decoded from the next counts so the registered flags line up with the registered counts.
    always_comb begin
        w_flags_nxt       = FLAGS_RST;
        w_flags_nxt.hblnk = (w_h_nxt >= H_BLANK);
        w_flags_nxt.vblnk = (w_v_nxt >= V_BLANK);
        w_flags_nxt.hsync = ((w_h_nxt >= H_SBEG) && (w_h_nxt <= H_SEND)) ? HS_ON : ~HS_ON;
        w_flags_nxt.vsync = ((w_v_nxt >= V_SBEG) && (w_v_nxt <= V_SEND)) ? VS_ON : ~VS_ON;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_restart     <= 1'b1;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_cnt   <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_flags       <= FLAGS_RST;
        end else if (ce) begin
            r_restart     <= 1'b0;
            r_hcount      <= w_h_nxt;
            r_vcount      <= w_v_nxt;
            r_line_start  <= w_line_evt;
            r_frame_start <= w_frame_evt;
            r_flags       <= w_flags_nxt;
            if (w_frame_evt && !r_restart) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    vga_sync_delay #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (4'(FLAGS_RST))
    ) u_sync_delay (
        .i_clk (pclk),
        .i_rst (rst),
        .i_ce  (ce),
        .i_dat (r_flags),
        .o_dat (w_flags_dly)
    );

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign frame_cnt   = r_frame_cnt;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign hsync       = w_flags_dly.hsync;
    assign vsync       = w_flags_dly.vsync;
    assign hblnk       = w_flags_dly.hblnk;
    assign vblnk       = w_flags_dly.vblnk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 1024x768 and 800x600 line timing, plus a tiny raster
// (12x6, SYNC_DELAY=2) checked cycle by cycle against a pixel-index reference model.
module tb_vga_timing_gen;

    localparam int XHT = 1328;
    localparam int SHT = 1056;
    localparam int THT = 12;
    localparam int TVT = 6;
    localparam int TFR = THT * TVT;
    localparam int TSD = 2;
    localparam logic [3:0] TRST = 4'b0100;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst_x, ce_x, rst_t, ce_t;

    logic [10:0] hc_x, vc_x, hc_s, vc_s;
    logic [3:0]  hc_t, vc_t;
    logic        hs_x, vs_x, hb_x, vb_x, ls_x, fs_x;
    logic        hs_s, vs_s, hb_s, vb_s, ls_s, fs_s;
    logic        hs_t, vs_t, hb_t, vb_t, ls_t, fs_t;
    logic [7:0]  fc_x, fc_s, fc_t;

    vga_timing_gen dut_x (
        .pclk(pclk), .rst(rst_x), .ce(ce_x),
        .hcount(hc_x), .vcount(vc_x),
        .hsync(hs_x), .vsync(vs_x), .hblnk(hb_x), .vblnk(vb_x),
        .line_start(ls_x), .frame_start(fs_x), .frame_cnt(fc_x)
    );

    vga_timing_gen #(
        .H_ACTIVE(vga_pkg::SVGA60_H_ACTIVE), .H_FP(vga_pkg::SVGA60_H_FP),
        .H_SYNC(vga_pkg::SVGA60_H_SYNC), .H_BP(vga_pkg::SVGA60_H_BP),
        .V_ACTIVE(vga_pkg::SVGA60_V_ACTIVE), .V_FP(vga_pkg::SVGA60_V_FP),
        .V_SYNC(vga_pkg::SVGA60_V_SYNC), .V_BP(vga_pkg::SVGA60_V_BP),
        .H_POL(1), .V_POL(1), .CW(11), .SYNC_DELAY(0)
    ) dut_s (
        .pclk(pclk), .rst(rst_x), .ce(ce_x),
        .hcount(hc_s), .vcount(vc_s),
        .hsync(hs_s), .vsync(vs_s), .hblnk(hb_s), .vblnk(vb_s),
        .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
    );

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(0), .CW(4), .SYNC_DELAY(TSD)
    ) dut_t (
        .pclk(pclk), .rst(rst_t), .ce(ce_t),
        .hcount(hc_t), .vcount(vc_t),
        .hsync(hs_t), .vsync(vs_t), .hblnk(hb_t), .vblnk(vb_t),
        .line_start(ls_t), .frame_start(fs_t), .frame_cnt(fc_t)
    );

    int n_asrt = 0;
    int n_fail = 0;
    bit chk_x = 0;
    bit chk_t = 0;

    // Reference state: pixel index since the last restart, plus pending-restart flag.
    bit xp, xstep;
    int xn;
    bit m_pend, m_ls, m_fs;
    int m_pos, m_frames;
    logic [3:0] m_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tflags(input int p);
        int h = p % THT;
        int v = p / THT;
        logic hs = (h >= 7 && h <= 8);
        logic vs = (v == 4) ? 1'b0 : 1'b1;
        return {hs, vs, logic'(h >= 6), logic'(v >= 3)};
    endfunction

    task automatic check_x();
        int h = xn % XHT;
        int v = xn / XHT;
        int hs = xn % SHT;
        int vs = xn / SHT;
        chk("x_h", hc_x, h);
        chk("x_v", vc_x, v);
        chk("x_hsync", hs_x, (h >= 1048 && h <= 1183) ? 0 : 1);
        chk("x_hblnk", hb_x, (h >= 1024) ? 1 : 0);
        chk("x_vsync", vs_x, (v >= 771 && v <= 776) ? 0 : 1);
        chk("x_vblnk", vb_x, (v >= 768) ? 1 : 0);
        chk("x_ls", ls_x, (xstep && h == 0) ? 1 : 0);
        chk("x_fs", fs_x, (xstep && xn == 0) ? 1 : 0);
        chk("x_fc", fc_x, 0);
        chk("s_h", hc_s, hs);
        chk("s_v", vc_s, vs);
        chk("s_hsync", hs_s, (hs >= 840 && hs <= 967) ? 1 : 0);
        chk("s_hblnk", hb_s, (hs >= 800) ? 1 : 0);
        chk("s_vsync", vs_s, (vs >= 601 && vs <= 604) ? 1 : 0);
        chk("s_vblnk", vb_s, (vs >= 600) ? 1 : 0);
        chk("s_ls", ls_s, (xstep && hs == 0) ? 1 : 0);
        chk("s_fs", fs_s, (xstep && xn == 0) ? 1 : 0);
        chk("s_fc", fc_s, 0);
    endtask

    task automatic check_t();
        chk("t_h", hc_t, m_pos % THT);
        chk("t_v", vc_t, m_pos / THT);
        chk("t_fc", fc_t, m_frames);
        chk("t_ls", ls_t, m_ls);
        chk("t_fs", fs_t, m_fs);
        chk("t_flags", {hs_t, vs_t, hb_t, vb_t}, m_q[0]);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
        if (rst_x) begin
            xp = 1; xn = 0; xstep = 0;
        end else if (ce_x) begin
            if (xp) begin xp = 0; xn = 0; end
            else xn++;
            xstep = 1;
        end else begin
            xstep = 0;
        end
        if (rst_t) begin
            m_pend = 1; m_pos = 0; m_frames = 0; m_ls = 0; m_fs = 0;
            m_q.delete();
            repeat (TSD + 1) m_q.push_back(TRST);
        end else if (ce_t) begin
            m_fs = 0;
            if (m_pend) begin
                m_pend = 0; m_pos = 0; m_fs = 1;
            end else begin
                m_pos++;
                if (m_pos == TFR) begin
                    m_pos = 0;
                    m_frames = (m_frames + 1) % 256;
                    m_fs = 1;
                end
            end
            m_ls = (m_pos % THT == 0);
            m_q.push_back(tflags(m_pos));
            void'(m_q.pop_front());
        end else begin
            m_ls = 0; m_fs = 0;
        end
        @(negedge pclk);
        if (chk_x) check_x();
        if (chk_t) check_t();
    endtask

    initial begin
        int last_x, last_s, last_f, prev_fc;
        bit prev_ce, wrapped;
        rst_x = 1; ce_x = 1; rst_t = 1; ce_t = 1;
        xp = 1; xn = 0; xstep = 0;
        m_pend = 1; m_pos = 0; m_frames = 0; m_ls = 0; m_fs = 0;
        repeat (TSD + 1) m_q.push_back(TRST);
        @(negedge pclk);
        repeat (3) tick();
        chk_x = 1;
        chk_t = 1;
        repeat (2) tick();

        // Default and 800x600 timing, ce held high: line periods and sync windows.
        rst_x = 0;
        last_x = -1;
        last_s = -1;
        for (int i = 0; i < 2 * XHT + 20; i++) begin
            tick();
            if (ls_x) begin
                if (last_x >= 0) chk("x_line_period", i - last_x, XHT);
                last_x = i;
            end
            if (ls_s) begin
                if (last_s >= 0) chk("s_line_period", i - last_s, SHT);
                last_s = i;
            end
        end
        for (int i = 0; i < 300; i++) begin
            ce_x = ($urandom_range(0, 3) != 0);
            tick();
        end
        ce_x = 1;

        // Tiny raster: restart pulse, then ce toggling 1,0,1,0 doubles the frame period.
        rst_t = 0;
        tick();
        chk("t_restart_fs", fs_t, 1);
        chk("t_restart_h", hc_t, 0);
        last_f = 0;
        prev_ce = 1;
        for (int i = 1; i <= 4 * TFR + 4; i++) begin
            ce_t = ((i % 2) == 0);
            tick();
            if (!ce_t) chk("t_no_pulse_ce0", {ls_t, fs_t}, 0);
            if (fs_t) begin
                chk("t_frame_period_half_ce", i - last_f, 2 * TFR);
                last_f = i;
            end
            prev_ce = ce_t;
        end

        // Delay line: blank/sync flags trail the counts by two cycles with ce high.
        ce_t = 1;
        repeat (3) tick();
        for (int i = 0; i < 3 * THT && hc_t != 4'd6; i++) tick();
        chk("t_at_h6", hc_t, 6);
        chk("t_hblnk_d0", hb_t, 0);
        tick();
        chk("t_hblnk_d1", hb_t, 0);
        tick();
        chk("t_hblnk_d2", hb_t, 1);
        chk("t_hsync_d1", hs_t, 0);
        tick();
        chk("t_hsync_d2", hs_t, 1);

        // Mid-frame reset, three cycles, then restart at (0,0).
        for (int i = 0; i < 3 * TFR && !(vc_t == 4'd3 && hc_t == 4'd5); i++) tick();
        chk("t_mid_v", vc_t, 3);
        rst_t = 1;
        repeat (3) begin
            tick();
            chk("t_rst_h", hc_t, 0);
            chk("t_rst_vsync", vs_t, 1);
        end
        rst_t = 0;
        tick();
        chk("t_after_rst_h", hc_t, 0);
        chk("t_after_rst_v", vc_t, 0);
        chk("t_after_rst_fs", fs_t, 1);

        // 256+ frames with random ce until frame_cnt rolls over.
        wrapped = 0;
        for (int i = 0; i < 32000 && !wrapped; i++) begin
            prev_fc = fc_t;
            ce_t = ($urandom_range(0, 3) != 0);
            tick();
            if (fs_t && fc_t == 8'd0 && prev_fc == 255) wrapped = 1;
        end
        chk("t_fc_wrap_255_to_0", wrapped, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
